// File: rtl/spc_dump_pkg.sv
// Shared constants for the SPC return-address stack and the dump FSM encoding.
package spc_dump_pkg;

  localparam int SPC_ADDR_WIDTH = 5;
  localparam int SPC_DATA_WIDTH = 19;
  localparam int SPC_DEPTH      = 32;

  // Dump sequencer states: one read, one capture, then hold for the spy bus.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FIN     = 3'd4
  } dump_state_e;

endpackage : spc_dump_pkg

// File: rtl/spc_dump.sv
// Spy-side reader for the SPC return-address stack: while the processor is
// halted, walks the stack from top-of-stack downward through the memory's
// spare read port and presents each entry over a valid/ready handshake.
module spc_dump
  import spc_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = SPC_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPC_DATA_WIDTH,
  parameter int DEPTH      = SPC_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halted,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [ADDR_WIDTH-1:0] spcptr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Full stack size expressed in the count port's width.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic [ADDR_WIDTH-1:0] k_q,     k_d;
  logic [ADDR_WIDTH:0]   n_q,     n_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  last_q,  last_d;
  logic                  err_q,   err_d;
  logic [ADDR_WIDTH:0]   count_eff;

  // Zero or out-of-range counts mean "dump the whole stack".
  assign count_eff = (count == '0 || count > DEPTH_C) ? DEPTH_C : count;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      n_q     <= n_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; losing halted mid-dump aborts straight to FIN.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    n_d     = n_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (halted) begin
            base_d  = spcptr;
            n_d     = count_eff;
            k_d     = '0;
            err_d   = 1'b0;
            state_d = ST_READ;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        if (!halted) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!halted) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          data_d  = mem_rdata;
          index_d = k_q;
          last_d  = ({1'b0, k_q} == n_q - 1'b1);
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (!halted) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (out_ready) begin
          if (last_q) begin
            state_d = ST_FIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state; the address generator counts down from base
  // and wraps naturally in ADDR_WIDTH bits.
  always_comb begin
    mem_re    = (state_q == ST_READ);
    mem_addr  = mem_re ? (base_q - k_q) : '0;
    out_valid = (state_q == ST_PRESENT);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
  end

  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign err       = err_q;

endmodule : spc_dump

// File: doc/spc_dump.md
Name: spc_dump

Overview:
- Debug/spy-side reader for the SPC return-address stack.
- While the processor is halted, it snapshots the stack pointer on request. It then walks the stack from top-of-stack downward, reading each entry through the stack memory's spare read port.
- Each entry is presented to the spy bus over a valid/ready handshake.
- It is the read-out counterpart to the microcode push/write path that fills the SPC memory.

Parameters:
ADDR_WIDTH, 5, stack address width
DATA_WIDTH, 19, stack entry width
DEPTH, 32, stack entries (2**ADDR_WIDTH)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
halted  input  1  processor halted; a dump is legal only while high
start  input  1  single-cycle request to begin a dump
count  input  ADDR_WIDTH+1  entries to dump; 0 or >DEPTH means DEPTH
spcptr  input  ADDR_WIDTH  live SPC stack pointer (top-of-stack address)
mem_re  output  1  read enable to the stack memory spare port
mem_addr  output  ADDR_WIDTH  read address to the stack memory
mem_rdata  input  DATA_WIDTH  read data; valid the cycle after mem_re
out_valid  output  1  out_data/out_index/out_last valid
out_ready  input  1  spy bus accepts the current word
out_data  output  DATA_WIDTH  stack entry
out_index  output  ADDR_WIDTH  depth below top (0 = top)
out_last  output  1  marks the final word of the dump
busy  output  1  dump in progress
done  output  1  one-cycle pulse when a dump ends (normally or aborted)
err  output  1  sticky error; cleared by the next accepted start

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0, including mem_addr, out_data and out_index. Internal base, k and n registers cleared.
- States: IDLE, READ, WAIT, PRESENT, FIN.
- IDLE:
  - start=1 with halted=1: latch base=spcptr and n=effective count, set k=0, clear err, go to READ.
  - start=1 with halted=0: set err=1, go to FIN; no memory reads are issued.
- READ:
  - mem_re=1 for exactly one cycle, with mem_addr = (base - k) mod DEPTH.
  - Go to WAIT.
- WAIT:
  - Capture mem_rdata into out_data. Set out_index=k and out_last=(k==n-1).
  - Go to PRESENT.
- PRESENT:
  - out_valid=1; out_data, out_index and out_last are held stable until the handshake.
  - On out_valid&&out_ready: if out_last, go to FIN; otherwise k=k+1 and go to READ.
- FIN:
  - done=1 for one cycle, then IDLE.
- busy=1 in READ, WAIT, PRESENT and FIN.
- Throughput: at most one word per 3 cycles. Latency from start to first out_valid is 3 cycles.
- Wrap-around: address arithmetic is modulo DEPTH, e.g. base=2, k=3 gives mem_addr=31.
- spcptr is sampled only at start; changes during a dump are ignored.
- start while busy is ignored. It does not restart the dump and does not set err.
- Abort: if halted drops while in READ, WAIT or PRESENT, the next edge does all of the following:
  - go to FIN;
  - force out_valid=0;
  - set err=1.
  This is the only case where out_valid falls without a handshake. Any in-flight read data is discarded.
- count width rule: effective n = (count==0 || count>DEPTH) ? DEPTH : count. k stays within 0..DEPTH-1.
- mem_re is never asserted outside READ, so the block never competes with the normal pop path while the processor runs.

Decomposition:
- Shared package holds:
  - SPC_ADDR_WIDTH=5, SPC_DATA_WIDTH=19, SPC_DEPTH=32 (common with the stack memory);
  - the dump state encoding: IDLE, READ, WAIT, PRESENT, FIN.
- Single module; no sub-module is warranted. The down-counting address generator stays inline.

Test Plan:
- Basic dump: halted=1, spcptr=5, memory[5..3]=0x1A,0x2B,0x3C, count=3, out_ready=1 → out_data sequence 0x1A,0x2B,0x3C; out_index 0,1,2; out_last only on the third word; done pulse after; err=0.
- Wrap: spcptr=1, count=4 → mem_addr sequence 1,0,31,30; four words with correct contents.
- Backpressure: out_ready=0 for 10 cycles on word 0 → out_valid held and out_data stable; no second mem_re until acceptance.
- Full stack: count=0 → exactly 32 words, out_last on index 31. A separate run with count=40 also gives exactly 32.
- Illegal start: halted=0 with start → no mem_re; err=1; done pulses within 2 cycles. A following legal start clears err.
- Abort and reset: halted drops in PRESENT of word 1 → out_valid low next cycle, err=1, done pulse, IDLE. reset asserted mid-dump → all outputs 0 immediately (asynchronously).
